// File: rtl/div_rate_ctrl_if.sv
// Control/status bundle for div_rate_ctrl: run/stop levels, divisor handshake
// and the divided-clock outputs. master = control logic, slave = controller.
interface div_rate_ctrl_if #(
  parameter int WIDTH = 26
);
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output start, stop, cfg_valid, cfg_div,
    input  cfg_ready, clk_out, tick, busy, cur_div
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_div,
    output cfg_ready, clk_out, tick, busy, cur_div
  );
endinterface

// File: rtl/div_rate_ctrl.sv
// Run/stop and divisor controller for the divided-clock generator.
// Define DIV_RATE_CTRL_ALIGN_EN to defer runtime divisor changes to the next wrap.
module div_rate_ctrl #(
  parameter int          WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 25000000
) (
  input  logic           clk_in,
  input  logic           rst,
  div_rate_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
`ifdef DIV_RATE_CTRL_ALIGN_EN
  localparam logic [1:0] PEND     = 2'd2;
`endif
  localparam logic [1:0] STOPPING = 2'd3;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] cur_div_reg, cur_div_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
`ifdef DIV_RATE_CTRL_ALIGN_EN
  logic [WIDTH-1:0] pend_div_reg, pend_div_next;
  logic             pend_vld_reg, pend_vld_next;
`endif

  logic             cfg_ready;
  logic             accept;
  logic             wrap;
  logic [WIDTH-1:0] cfg_div_clamped;

  assign cfg_ready       = (state_reg == IDLE) || (state_reg == RUN);
  assign accept          = bus.cfg_valid && cfg_ready;
  assign wrap            = (cnt_reg == cur_div_reg);
  assign cfg_div_clamped = (bus.cfg_div == '0) ? WIDTH'(1) : bus.cfg_div;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cur_div_next = cur_div_reg;
    clk_out_next = clk_out_reg;
    tick_next    = 1'b0;
`ifdef DIV_RATE_CTRL_ALIGN_EN
    pend_div_next = pend_div_reg;
    pend_vld_next = pend_vld_reg;
`endif

    // Every non-idle state counts the same way; the case below only adds transitions.
    if (state_reg != IDLE) begin
      if (wrap) begin
        cnt_next     = '0;
        clk_out_next = ~clk_out_reg;
        tick_next    = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        clk_out_next = 1'b0;
        if (accept)
          cur_div_next = cfg_div_clamped;
        if (bus.start && !bus.stop)
          state_next = RUN;
      end
      RUN: begin
`ifdef DIV_RATE_CTRL_ALIGN_EN
        if (accept) begin
          pend_div_next = cfg_div_clamped;
          pend_vld_next = 1'b1;
        end
        if (bus.stop)
          state_next = STOPPING;
        else if (accept)
          state_next = PEND;
`else
        // Immediate reload: restart the half-period but keep the output level.
        if (accept) begin
          cur_div_next = cfg_div_clamped;
          cnt_next     = '0;
        end
        if (bus.stop)
          state_next = STOPPING;
`endif
      end
`ifdef DIV_RATE_CTRL_ALIGN_EN
      PEND: begin
        if (wrap) begin
          cur_div_next  = pend_div_reg;
          pend_vld_next = 1'b0;
        end
        if (bus.stop)
          state_next = STOPPING;
        else if (wrap)
          state_next = RUN;
      end
`endif
      STOPPING: begin
        if (wrap) begin
`ifdef DIV_RATE_CTRL_ALIGN_EN
          if (pend_vld_reg) begin
            cur_div_next  = pend_div_reg;
            pend_vld_next = 1'b0;
          end
`endif
          // Leaving only on a falling wrap guarantees a full high phase.
          if (clk_out_reg)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cur_div_reg <= DEF_DIV;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
`ifdef DIV_RATE_CTRL_ALIGN_EN
      pend_div_reg <= '0;
      pend_vld_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cur_div_reg <= cur_div_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
`ifdef DIV_RATE_CTRL_ALIGN_EN
      pend_div_reg <= pend_div_next;
      pend_vld_reg <= pend_vld_next;
`endif
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.clk_out   = clk_out_reg;
  assign bus.tick      = tick_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.cur_div   = cur_div_reg;

endmodule

// File: doc/div_rate_ctrl.md
# div_rate_ctrl

Run/stop and rate controller for the board's divided-clock generator. It owns the terminal-count register of a divide-by-counter and exposes a valid/ready interface for reprogramming the divisor at runtime. Divisor changes and stops complete only at counter wrap boundaries, so `clk_out` never produces a runt phase. It sits between the top-level control logic (buttons/UART command decoder) and every consumer of the slow clock and tick.

## Interface
- `WIDTH`, 26: width of divisor and counter.
- `DEFAULT_DIV`, 25000000: divisor loaded at reset. Must be ≥1 and fit in `WIDTH`.

Ports:
- `clk_in` input 1: sole clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level; begins running when in IDLE.
- `stop` input 1: level; requests a glitch-free stop.
- `cfg_valid` input 1: new divisor offered.
- `cfg_div` input WIDTH: offered divisor; 0 is clamped to 1.
- `cfg_ready` output 1: divisor can be accepted this cycle.
- `clk_out` output 1: divided clock, registered.
- `tick` output 1: one-cycle pulse on every `clk_out` edge.
- `busy` output 1: high in any state except IDLE.
- `cur_div` output WIDTH: divisor currently in effect.

## Operation
- Counter `cnt` counts 0..`cur_div`. On the edge where `cnt==cur_div` (the wrap):
  - `cnt<=0`
  - `clk_out<=~clk_out`
  - `tick<=1`
- Half period is `cur_div+1` cycles. On every other edge in a counting state, `cnt<=cnt+1` and `tick<=0`.
- FSM states: IDLE, RUN, PEND, STOPPING.
  - IDLE: `cnt=0`, `clk_out` held 0, `tick=0`, `cfg_ready=1`. An accepted config loads `cur_div` on the next edge. `start && !stop` → RUN with `cnt=0`.
  - RUN: counting, `cfg_ready=1`. An accepted config is latched into `pend_div` → PEND. `stop` → STOPPING.
  - PEND: counting, `cfg_ready=0`. At wrap, `cur_div<=pend_div` → RUN. The new value governs the following half-period. `stop` → STOPPING with the pending value kept.
  - STOPPING: counting, `cfg_ready=0`.
    - Any pending divisor is applied at the first wrap.
    - At a wrap where `clk_out` is 1: `clk_out<=0`, `tick<=1`, `cnt<=0` → IDLE.
    - At a wrap where `clk_out` is 0: it toggles to 1 and counting continues.
- Handshake: transfer occurs on an edge with `cfg_valid && cfg_ready`. `cfg_ready` is a Moore output of state only.
- Simultaneous events:
  - `start` and `stop` in IDLE: stop wins, stay IDLE.
  - `cfg_valid` and `start` in IDLE: both take effect, and the new divisor is used from the first half-period.
  - `cfg_valid` and `stop` in RUN: config is accepted, and the state goes to STOPPING with the value pending.
- `rst` at any time, including mid-period or in PEND: all state returns to reset values next edge and `pend_div` is discarded.

## Timing
- Reset values:
  - `clk_out=0`, `tick=0`, `busy=0`, `cfg_ready=1`
  - `cur_div=DEFAULT_DIV`, `cnt=0`, state IDLE
- `start` sampled at edge N (IDLE) gives `busy=1` after edge N. The first `tick` and `clk_out` rise follow edge N+1+`cur_div`.
- `tick` is registered and coincides with the cycle `clk_out` shows its new value.
- Stop latency: at most 2·(`cur_div`+1) cycles from `stop` to IDLE. `clk_out` always ends low after a full high phase.

## Configuration
- Macro `DIV_RATE_CTRL_ALIGN_EN`.
  - Defined: behaviour as above; divisor changes in RUN go through PEND and apply at wrap.
  - Undefined: PEND is not built. An accepted config in RUN loads `cur_div` immediately and clears `cnt` to 0. `clk_out` keeps its level, and no `tick` is generated by the load. In STOPPING, `cfg_ready=0` still holds.

## Test plan
- Reset with `DEFAULT_DIV=3`, then `start` for 1 cycle: `tick` every 4 cycles; `clk_out` period 8 cycles, high 4/low 4; `cur_div=3`.
- In RUN with `cur_div=3`, offer `cfg_div=1` at `cnt=1` (ALIGN_EN): accepted, `cfg_ready=0` until wrap. Current half-period stays 4 cycles, subsequent half-periods are 2. Without the macro: `cnt` restarts at 0 and the next half-period is 2 cycles.
- `stop` while `clk_out=0`, `cur_div=3`: `clk_out` completes a full 4-cycle high phase, falls, and `busy` drops on the same edge; no further `tick`.
- `cfg_div=0` in IDLE, then `start`: `cur_div=1`, `tick` every 2 cycles.
- Assert `rst` in PEND mid-count: next edge `clk_out=0`, `cnt=0`, `cur_div=DEFAULT_DIV`, IDLE, `cfg_ready=1`; the pending value is never applied.
- `start` and `stop` high together in IDLE: remains IDLE, `busy=0`, `clk_out=0`.
